// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - vending machine transaction controller
//
// Purpose: tracks customer credit from coin-insert events, dispenses an item
// when credit covers PRICE, and refunds leftover credit one coin at a time
// while respecting the coin inventory reported by the downstream counter.
//
// Ports:
//   CLK        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   coin_in    in   raw coin-detect level (asynchronous to CLK)
//   buy        in   purchase request, rising-edge detected
//   cancel     in   refund request, rising-edge detected
//   coins[7:0] in   current coin inventory from the coin counter
//   enable     out  coin-accept window to the counter
//   inc_sig    out  one-cycle pulse per accepted coin
//   dec_sig    out  one-cycle pulse per refunded coin
//   dispense   out  item release, held DISP_CYCLES cycles
//   reject     out  one-cycle pulse per refused coin
//   credit[3:0] out current customer credit
//   no_change  out  sticky: a refund was cut short by an empty inventory
module vend_controller #(
   parameter int PRICE       = 3,
   parameter int MAX_CREDIT  = 9,
   parameter int DISP_CYCLES = 4
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       coin_in,
   input  logic       buy,
   input  logic       cancel,
   input  logic [7:0] coins,
   output logic       enable,
   output logic       inc_sig,
   output logic       dec_sig,
   output logic       dispense,
   output logic       reject,
   output logic [3:0] credit,
   output logic       no_change
);

   localparam int CW = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
   localparam logic [3:0]    PRICE_C   = 4'(PRICE);
   localparam logic [3:0]    MAX_C     = 4'(MAX_CREDIT);
   localparam logic [CW-1:0] DISP_LAST = CW'(DISP_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, REFUND} state_t;

   state_t        state, state_nxt;
   logic          coin_s1, coin_s2, coin_prev;
   logic          buy_prev, cancel_prev;
   logic          refund_gap, refund_gap_nxt;
   logic [CW-1:0] disp_cnt, disp_cnt_nxt;
   logic [3:0]    credit_nxt;
   logic          enable_nxt, inc_nxt, dec_nxt, disp_nxt, reject_nxt, no_change_nxt;
   logic          coin_evt, buy_evt, cancel_evt;

   // coin_s2 is the synchronized level; the event fires on its first high cycle.
   assign coin_evt   = coin_s2 & ~coin_prev;
   assign buy_evt    = buy & ~buy_prev;
   assign cancel_evt = cancel & ~cancel_prev;

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         coin_s1     <= 1'b0;
         coin_s2     <= 1'b0;
         coin_prev   <= 1'b0;
         buy_prev    <= 1'b0;
         cancel_prev <= 1'b0;
         refund_gap  <= 1'b0;
         disp_cnt    <= '0;
         credit      <= 4'd0;
         enable      <= 1'b1;
         inc_sig     <= 1'b0;
         dec_sig     <= 1'b0;
         dispense    <= 1'b0;
         reject      <= 1'b0;
         no_change   <= 1'b0;
      end else begin
         state       <= state_nxt;
         coin_s1     <= coin_in;
         coin_s2     <= coin_s1;
         coin_prev   <= coin_s2;
         buy_prev    <= buy;
         cancel_prev <= cancel;
         refund_gap  <= refund_gap_nxt;
         disp_cnt    <= disp_cnt_nxt;
         credit      <= credit_nxt;
         enable      <= enable_nxt;
         inc_sig     <= inc_nxt;
         dec_sig     <= dec_nxt;
         dispense    <= disp_nxt;
         reject      <= reject_nxt;
         no_change   <= no_change_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      refund_gap_nxt = refund_gap;
      disp_cnt_nxt   = disp_cnt;
      credit_nxt     = credit;
      inc_nxt        = 1'b0;
      dec_nxt        = 1'b0;
      disp_nxt       = 1'b0;
      reject_nxt     = 1'b0;
      no_change_nxt  = no_change;

      case (state)
         IDLE, CREDIT: begin
            if (coin_evt && (credit < MAX_C)) begin
               // An accepted coin swallows any buy/cancel edge in the same cycle.
               credit_nxt    = credit + 4'd1;
               inc_nxt       = 1'b1;
               no_change_nxt = 1'b0;
               state_nxt     = CREDIT;
            end else begin
               reject_nxt = coin_evt;
               if (cancel_evt && (credit != 4'd0)) begin
                  state_nxt      = REFUND;
                  refund_gap_nxt = 1'b0;
               end else if (buy_evt && (credit >= PRICE_C)) begin
                  credit_nxt   = credit - PRICE_C;
                  state_nxt    = DISPENSE;
                  disp_cnt_nxt = DISP_LAST;
                  disp_nxt     = 1'b1;
               end
            end
         end
         DISPENSE: begin
            reject_nxt = coin_evt;
            if (disp_cnt == '0) begin
               state_nxt      = (credit != 4'd0) ? REFUND : IDLE;
               refund_gap_nxt = 1'b0;
            end else begin
               disp_cnt_nxt = disp_cnt - CW'(1);
               disp_nxt     = 1'b1;
            end
         end
         REFUND: begin
            reject_nxt = coin_evt;
            if (!refund_gap) begin
               if (coins != 8'd0) begin
                  dec_nxt        = 1'b1;
                  credit_nxt     = credit - 4'd1;
                  refund_gap_nxt = 1'b1;
               end else begin
                  // Inventory exhausted: the rest of the credit is forfeited.
                  no_change_nxt = 1'b1;
                  credit_nxt    = 4'd0;
                  state_nxt     = IDLE;
               end
            end else begin
               refund_gap_nxt = 1'b0;
               if (credit == 4'd0)
                  state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      enable_nxt = (state_nxt == IDLE) || (state_nxt == CREDIT);
   end

endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - scoreboard testbench for vend_controller
module tb_vend_controller;

   localparam int PRICE       = 3;
   localparam int MAX_CREDIT  = 9;
   localparam int DISP_CYCLES = 4;

   localparam int EV_INC  = 0;
   localparam int EV_REJ  = 1;
   localparam int EV_DISP = 2;
   localparam int EV_DEC  = 3;
   localparam int EV_NC   = 4;

   typedef struct {
      int kind;
      int cr;
   } ev_t;

   logic       CLK = 1'b0;
   logic       reset = 1'b0;
   logic       coin_in = 1'b0;
   logic       buy = 1'b0;
   logic       cancel = 1'b0;
   logic [7:0] coins;
   logic       enable, inc_sig, dec_sig, dispense, reject, no_change;
   logic [3:0] credit;

   // Coin inventory counter emulation feeding the coins input.
   logic [7:0] inv = 8'd0;
   logic       inv_load = 1'b0;
   logic [7:0] inv_load_val = 8'd0;

   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_fails  = 0;
   int  m_credit = 0;
   int  m_inv    = 0;
   bit  m_nc     = 0;

   vend_controller #(
      .PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT), .DISP_CYCLES(DISP_CYCLES)
   ) dut (
      .CLK(CLK), .reset(reset), .coin_in(coin_in), .buy(buy), .cancel(cancel),
      .coins(coins), .enable(enable), .inc_sig(inc_sig), .dec_sig(dec_sig),
      .dispense(dispense), .reject(reject), .credit(credit), .no_change(no_change)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (inv_load)     inv <= inv_load_val;
      else if (inc_sig) inv <= inv + 8'd1;
      else if (dec_sig) inv <= inv - 8'd1;
   end
   assign coins = inv;

   function automatic string kname(input int k);
      case (k)
         EV_INC:  return "inc";
         EV_REJ:  return "reject";
         EV_DISP: return "dispense";
         EV_DEC:  return "dec";
         default: return "no_change";
      endcase
   endfunction

   task automatic chk(input bit ok, input string name, input int act, input int req);
      n_checks++;
      if (!ok) begin
         n_fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic expect_ev(input int kind);
      ev_t e;
      if (exp_q.size() == 0) begin
         chk(0, {"unexpected_", kname(kind)}, int'(credit), -1);
      end else begin
         e = exp_q.pop_front();
         chk(e.kind == kind, {"event_kind_", kname(kind)}, kind, e.kind);
         chk(e.cr == int'(credit), {"event_credit_", kname(kind)}, int'(credit), e.cr);
      end
   endtask

   task automatic monitor();
      int dlen = 0;
      bit dprev = 0, nprev = 0, decprev = 0;
      forever begin
         @(negedge CLK);
         if (!reset) begin
            dlen = 0; dprev = 0; nprev = 0; decprev = 0;
         end else begin
            if (inc_sig || dec_sig)
               chk(!(inc_sig && dec_sig) && int'(credit) <= MAX_CREDIT,
                   "inc_dec_invariant", {inc_sig, dec_sig, credit}, 0);
            if (inc_sig) expect_ev(EV_INC);
            if (reject) expect_ev(EV_REJ);
            if (dispense && !dprev) expect_ev(EV_DISP);
            if (dec_sig) expect_ev(EV_DEC);
            if (no_change && !nprev) expect_ev(EV_NC);
            if (dec_sig && decprev) chk(0, "dec_width", 2, 1);
            if (dispense) dlen++;
            else if (dprev) begin
               chk(dlen == DISP_CYCLES, "dispense_len", dlen, DISP_CYCLES);
               dlen = 0;
            end
            dprev = dispense; nprev = no_change; decprev = dec_sig;
         end
      end
   endtask

   task automatic watchdog();
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   endtask

   task automatic step();
      @(negedge CLK);
   endtask

   task automatic push(input int k, input int c);
      ev_t e;
      e.kind = k; e.cr = c;
      exp_q.push_back(e);
   endtask

   task automatic load_inv(input int v);
      step();
      inv_load = 1'b1; inv_load_val = 8'(v);
      step();
      inv_load = 1'b0;
      m_inv = v;
   endtask

   task automatic model_coin();
      if (m_credit < MAX_CREDIT) begin
         m_credit++; m_inv++; m_nc = 0;
         push(EV_INC, m_credit);
      end else begin
         push(EV_REJ, m_credit);
      end
   endtask

   task automatic model_refund();
      while (m_credit > 0) begin
         if (m_inv > 0) begin
            m_credit--; m_inv--;
            push(EV_DEC, m_credit);
         end else begin
            if (!m_nc) push(EV_NC, 0);
            m_nc = 1; m_credit = 0;
         end
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      repeat (2) step();
      while (!enable && n < 300) begin step(); n++; end
      if (!enable) chk(0, "idle_timeout", 0, 1);
      step();
   endtask

   task automatic do_coin(input int hold);
      model_coin();
      step();
      coin_in = 1'b1;
      repeat (hold) step();
      coin_in = 1'b0;
      repeat (4) step();
   endtask

   task automatic do_press(input bit b, input bit c);
      if (c && m_credit > 0) begin
         model_refund();
      end else if (b && m_credit >= PRICE) begin
         m_credit -= PRICE;
         push(EV_DISP, m_credit);
         model_refund();
      end
      step();
      buy = b; cancel = c;
      step();
      buy = 1'b0; cancel = 1'b0;
      wait_idle();
   endtask

   initial begin
      fork
         monitor();
         watchdog();
      join_none

      // Reset state
      repeat (3) step();
      #1;
      chk({enable, inc_sig, dec_sig, dispense, reject, no_change, credit} == 10'b10000_0_0000,
          "reset_outputs", {enable, inc_sig, dec_sig, dispense, reject, no_change, credit}, 10'h200);
      reset = 1'b1;
      load_inv(100);

      // First coin: exact inc_sig timing, single pulse while held
      model_coin();
      step();
      coin_in = 1'b1;
      @(posedge CLK); #1 chk(inc_sig == 0, "inc_edge_k", inc_sig, 0);
      @(posedge CLK); #1 chk(inc_sig == 0, "inc_edge_k1", inc_sig, 0);
      @(posedge CLK); #1 chk(inc_sig == 1 && credit == 1, "inc_edge_k2", {inc_sig, credit}, 5'h11);
      @(posedge CLK); #1 chk(inc_sig == 0, "inc_held_once", inc_sig, 0);
      coin_in = 1'b0;
      repeat (4) step();

      // Purchase with one coin of change
      repeat (3) do_coin(2);
      do_press(1, 0);
      chk(credit == 0 && enable == 1, "after_buy_idle", {enable, credit}, 5'h10);

      // Buy with too little credit, then cancel
      repeat (2) do_coin(3);
      do_press(1, 0);
      chk(credit == 2, "buy_ignored_credit", credit, 2);
      do_press(0, 1);
      chk(credit == 0, "cancel_refund_credit", credit, 0);

      // Saturation and reject, then cancel beating buy
      repeat (10) do_coin(1);
      chk(credit == MAX_CREDIT, "max_credit", credit, MAX_CREDIT);
      do_press(1, 1);
      chk(credit == 0, "refund_of_max", credit, 0);

      // Truncated refund with one coin left in the machine
      repeat (3) do_coin(2);
      load_inv(1);
      do_press(0, 1);
      chk(no_change == 1 && credit == 0 && enable == 1, "no_change_set", {no_change, enable, credit}, 6'h30);
      do_coin(2);
      chk(no_change == 0, "no_change_cleared", no_change, 0);
      do_press(0, 1);
      load_inv(100);

      // Reset during dispense cycle 2
      repeat (5) do_coin(2);
      push(EV_DISP, 2);
      step();
      buy = 1'b1;
      step();
      buy = 1'b0;
      step();
      #2 reset = 1'b0;
      #1 chk({dispense, credit, enable} == 6'b0_0000_1, "reset_mid_dispense", {dispense, credit, enable}, 1);
      exp_q.delete();
      m_credit = 0; m_nc = 0;
      repeat (2) step();
      #2 reset = 1'b1;
      repeat (20) step();
      chk(dispense == 0 && credit == 0, "quiet_after_reset", {dispense, credit}, 0);

      // Coin event and buy edge in the same cycle: coin wins, buy dropped
      repeat (3) do_coin(2);
      model_coin();
      step();
      coin_in = 1'b1;
      @(posedge CLK);
      @(posedge CLK); #1 buy = 1'b1;
      @(posedge CLK); #1 buy = 1'b0;
      repeat (2) step();
      coin_in = 1'b0;
      repeat (6) step();
      chk(credit == 4 && enable == 1 && dispense == 0, "coin_beats_buy", {dispense, enable, credit}, 6'h14);
      do_press(0, 1);

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r <= 4)      do_coin($urandom_range(1, 4));
         else if (r == 5) do_press(1, 0);
         else if (r == 6) do_press(0, 1);
         else if (r == 7) do_press(1, 1);
         else if (r == 8) load_inv($urandom_range(0, 3));
         else             load_inv(100);
      end
      do_press(0, 1);
      chk(int'(credit) == m_credit, "final_credit", credit, m_credit);

      repeat (10) step();
      chk(exp_q.size() == 0, "events_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
